// File: rtl/urng_taus_mc_pkg.sv
// Shared constants, types and helpers for the multi-channel taus88 uniform RNG.
// The three Tausworthe components each have their own shift triple, mask and minimum legal seed.
package urng_taus_mc_pkg;

    localparam int S0_L = 13;
    localparam int S0_R = 19;
    localparam int S0_M = 12;
    localparam int S1_L = 2;
    localparam int S1_R = 25;
    localparam int S1_M = 4;
    localparam int S2_L = 3;
    localparam int S2_R = 11;
    localparam int S2_M = 17;

    localparam logic [31:0] MASK0 = 32'hFFFF_FFFE;
    localparam logic [31:0] MASK1 = 32'hFFFF_FFF8;
    localparam logic [31:0] MASK2 = 32'hFFFF_FFF0;

    // Component k lives at index [k]; a component below its minimum would lock up at zero.
    localparam logic [2:0][31:0] MIN_SEED = {32'd16, 32'd8, 32'd2};
    localparam logic [2:0][31:0] DEF_SEED = {32'h0F1E_2D3C, 32'h9ABC_DEF0, 32'h1234_5678};
    localparam logic [31:0]      CH_SALT  = 32'h9E37_79B9;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } urng_state_e;

    function automatic logic [31:0] fixup(input logic [31:0] v, input logic [31:0] min_v);
        return (v < min_v) ? (v | min_v) : v;
    endfunction

    function automatic logic [31:0] chan_salt(input int unsigned c);
        logic [31:0] cv;
        cv = 32'(c);
        return cv * CH_SALT;
    endfunction

endpackage

// File: rtl/urng_taus_mc_if.sv
// Seed-load controls plus the bundled valid/ready sample stream of the RNG.
// master = generator side, slave = seed writer / sample consumer side.
interface urng_taus_mc_if #(
    parameter int NUM_CH = 2,
    parameter int OUT_W  = 32
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                    seed_we;
    logic [CHW-1:0]          seed_ch;
    logic [1:0]              seed_sel;
    logic [31:0]             seed_data;
    logic                    seed_go;
    logic                    out_valid;
    logic                    out_ready;
    logic [NUM_CH*OUT_W-1:0] out_data;
    logic                    warming;

    modport master (
        input  seed_we, seed_ch, seed_sel, seed_data, seed_go, out_ready,
        output out_valid, out_data, warming
    );

    modport slave (
        output seed_we, seed_ch, seed_sel, seed_data, seed_go, out_ready,
        input  out_valid, out_data, warming
    );

endinterface

// File: rtl/urng_taus_mc_step.sv
// One combinational taus88 state transition: next component states and their XOR result.
// Bits shifted past either end are discarded (plain 32-bit shifts).
module urng_taus_mc_step
    import urng_taus_mc_pkg::*;
(
    input  logic [31:0] a0_i,
    input  logic [31:0] a1_i,
    input  logic [31:0] a2_i,
    output logic [31:0] s0_o,
    output logic [31:0] s1_o,
    output logic [31:0] s2_o,
    output logic [31:0] r_o
);

    assign s0_o = ((a0_i ^ (a0_i << S0_L)) >> S0_R) ^ ((a0_i & MASK0) << S0_M);
    assign s1_o = ((a1_i ^ (a1_i << S1_L)) >> S1_R) ^ ((a1_i & MASK1) << S1_M);
    assign s2_o = ((a2_i ^ (a2_i << S2_L)) >> S2_R) ^ ((a2_i & MASK2) << S2_M);
    assign r_o  = s0_o ^ s1_o ^ s2_o;

endmodule

// File: rtl/urng_taus_mc.sv
// NUM_CH lockstep taus88 generators with shadow seeds, warm-up discard and one output register.
// First sample WARMUP+2 edges after reset/seed_go; output holds (no step) while valid & ~ready.
module urng_taus_mc
    import urng_taus_mc_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int OUT_W  = 32,
    parameter int WARMUP = 16
) (
    input  logic              clk,
    input  logic              rst,
    urng_taus_mc_if.master    bus
);

    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0][2:0][31:0] shadow_q;
    logic [NUM_CH-1:0][2:0][31:0] st_q, st_d;
    logic [NUM_CH-1:0][2:0][31:0] nx;
    logic [NUM_CH-1:0][31:0]      r;
    logic [NUM_CH*OUT_W-1:0]      samp;
    logic [NUM_CH*OUT_W-1:0]      dat_q, dat_d;
    urng_state_e                  state_q, state_d;
    logic [15:0]                  cnt_q, cnt_d;
    logic                         vld_q, vld_d;
    logic                         step_en;
    logic                         load_fix;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        urng_taus_mc_step u_step (
            .a0_i (st_q[c][0]),
            .a1_i (st_q[c][1]),
            .a2_i (st_q[c][2]),
            .s0_o (nx[c][0]),
            .s1_o (nx[c][1]),
            .s2_o (nx[c][2]),
            .r_o  (r[c])
        );
    end

    // Out-of-range channel or seed_sel==3 simply never matches any shadow slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < 3; k++) begin
                    shadow_q[c][k] <= DEF_SEED[k] ^ chan_salt(c);
                end
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < 3; k++) begin
                    if (bus.seed_we && bus.seed_ch == CHW'(c) && bus.seed_sel == 2'(k)) begin
                        shadow_q[c][k] <= bus.seed_data;
                    end
                end
            end
        end
    end

    always_comb begin
        samp = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            samp[c*OUT_W +: OUT_W] = r[c][31 -: OUT_W];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vld_d    = vld_q;
        dat_d    = dat_q;
        step_en  = 1'b0;
        load_fix = 1'b0;
        if (bus.seed_go) begin
            load_fix = 1'b1;
            cnt_d    = 16'(WARMUP);
            vld_d    = 1'b0;
            state_d  = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    if (cnt_q == 16'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        step_en = 1'b1;
                        cnt_d   = cnt_q - 16'd1;
                    end
                end
                ST_RUN: begin
                    if (!vld_q || bus.out_ready) begin
                        step_en = 1'b1;
                        vld_d   = 1'b1;
                        dat_d   = samp;
                    end
                end
                default: state_d = ST_WARMUP;
            endcase
        end
    end

    always_comb begin
        st_d = st_q;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (load_fix) begin
                    st_d[c][k] = fixup(shadow_q[c][k], MIN_SEED[k]);
                end else if (step_en) begin
                    st_d[c][k] = nx[c][k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_WARMUP;
            cnt_q   <= 16'(WARMUP);
            vld_q   <= 1'b0;
            dat_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < 3; k++) begin
                    st_q[c][k] <= fixup(DEF_SEED[k] ^ chan_salt(c), MIN_SEED[k]);
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
            st_q    <= st_d;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.out_data  = dat_q;
    assign bus.warming   = (state_q == ST_WARMUP);

endmodule
